// File: rtl/prco_mem_arb_if.sv
// Bus bundle between the two requesters (fetch and load/store), the arbiter
// and a single-port synchronous memory.
interface prco_mem_arb_if #(
  parameter int P_ADDR_W = 16
);
  logic                i_fetch_req;
  logic [P_ADDR_W-1:0] i_fetch_addr;
  logic                q_fetch_ack;
  logic [15:0]         q_fetch_data;

  logic                i_data_req;
  logic                i_data_we;
  logic [P_ADDR_W-1:0] i_data_addr;
  logic [15:0]         i_data_din;
  logic                q_data_ack;
  logic [15:0]         q_data_dout;

  logic                q_mem_ce;
  logic                q_mem_we;
  logic [P_ADDR_W-1:0] q_mem_addr;
  logic [15:0]         q_mem_dina;
  logic [15:0]         i_mem_douta;

  logic                q_busy;

  // Arbiter side
  modport slave (
    input  i_fetch_req, i_fetch_addr,
    output q_fetch_ack, q_fetch_data,
    input  i_data_req, i_data_we, i_data_addr, i_data_din,
    output q_data_ack, q_data_dout,
    output q_mem_ce, q_mem_we, q_mem_addr, q_mem_dina,
    input  i_mem_douta,
    output q_busy
  );

  // Requester / memory side
  modport master (
    output i_fetch_req, i_fetch_addr,
    input  q_fetch_ack, q_fetch_data,
    output i_data_req, i_data_we, i_data_addr, i_data_din,
    input  q_data_ack, q_data_dout,
    input  q_mem_ce, q_mem_we, q_mem_addr, q_mem_dina,
    output i_mem_douta,
    input  q_busy
  );
endinterface

// File: rtl/prco_mem_arb.sv
// Two-port (instruction fetch / load-store) arbiter onto one synchronous memory.
// Each transaction walks IDLE -> ISSUE -> WAIT -> ACK; every output is registered.
module prco_mem_arb #(
  parameter int P_RR     = 1,
  parameter int P_ADDR_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  prco_mem_arb_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t              state_q;
  logic                last_data_q;
  logic                gnt_data_q;
  logic                we_q;

  logic                fetch_ack_q;
  logic [15:0]         fetch_data_q;
  logic                data_ack_q;
  logic [15:0]         data_dout_q;
  logic                mem_ce_q;
  logic                mem_we_q;
  logic [P_ADDR_W-1:0] mem_addr_q;
  logic [15:0]         mem_dina_q;
  logic                busy_q;

  logic                any_req_d;
  logic                gnt_data_d;
  logic                we_d;
  logic [P_ADDR_W-1:0] addr_d;
  logic [15:0]         din_d;

  // Grant decision, only consumed in IDLE
  always_comb begin
    any_req_d  = bus.i_fetch_req | bus.i_data_req;
    gnt_data_d = 1'b0;
    if (bus.i_data_req && !bus.i_fetch_req) begin
      gnt_data_d = 1'b1;
    end else if (bus.i_data_req && bus.i_fetch_req) begin
      gnt_data_d = (P_RR != 0) ? !last_data_q : 1'b1;
    end
    we_d   = gnt_data_d & bus.i_data_we;
    addr_d = gnt_data_d ? bus.i_data_addr : bus.i_fetch_addr;
    din_d  = gnt_data_d ? bus.i_data_din : 16'h0000;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      last_data_q  <= 1'b1;
      gnt_data_q   <= 1'b0;
      we_q         <= 1'b0;
      fetch_ack_q  <= 1'b0;
      fetch_data_q <= 16'h0000;
      data_ack_q   <= 1'b0;
      data_dout_q  <= 16'h0000;
      mem_ce_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_dina_q   <= 16'h0000;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            gnt_data_q  <= gnt_data_d;
            last_data_q <= gnt_data_d;
            we_q        <= we_d;
            mem_ce_q    <= 1'b1;
            mem_we_q    <= we_d;
            mem_addr_q  <= addr_d;
            mem_dina_q  <= din_d;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_ce_q <= 1'b0;
          mem_we_q <= 1'b0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          // Memory read data is valid this cycle; stores keep the old load result
          if (gnt_data_q) begin
            data_ack_q <= 1'b1;
            if (!we_q) begin
              data_dout_q <= bus.i_mem_douta;
            end
          end else begin
            fetch_ack_q  <= 1'b1;
            fetch_data_q <= bus.i_mem_douta;
          end
          state_q <= S_ACK;
        end
        S_ACK: begin
          fetch_ack_q <= 1'b0;
          data_ack_q  <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.q_fetch_ack  = fetch_ack_q;
  assign bus.q_fetch_data = fetch_data_q;
  assign bus.q_data_ack   = data_ack_q;
  assign bus.q_data_dout  = data_dout_q;
  assign bus.q_mem_ce     = mem_ce_q;
  assign bus.q_mem_we     = mem_we_q;
  assign bus.q_mem_addr   = mem_addr_q;
  assign bus.q_mem_dina   = mem_dina_q;
  assign bus.q_busy       = busy_q;

endmodule
